adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 176 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one external adder among N_REQ requesters
//
// Purpose:
//   Accepts one add request at a time from N_REQ requesters using a rotating
//   priority. It presents the captured operands to an external adder with a
//   fixed latency of LAT cycles, then returns the WIDTH+1-bit sum with the
//   requester id through a valid/ready response handshake.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   [N_REQ]        per-requester request
//   req_ready  out  [N_REQ]        one-hot accept strobe (combinational, IDLE only)
//   req_a      in   [N_REQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   [N_REQ*WIDTH]  operand B, same packing as req_a
//   add_a      out  [WIDTH]        operand A to the shared adder
//   add_b      out  [WIDTH]        operand B to the shared adder
//   add_valid  out  1              adder input strobe, one cycle per operation
//   add_c      in   [WIDTH+1]      adder sum including carry
//   rsp_valid  out  1              response valid
//   rsp_id     out  [clog2(N_REQ)] id of the requester that owns the response
//   rsp_data   out  [WIDTH+1]      sum including carry
//   rsp_ready  in   1              response accept
//   busy       out  1              high whenever an operation is in flight

module adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int LAT   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    output logic                       add_valid,
    input  logic [WIDTH:0]             add_c,
    output logic                       rsp_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH:0]             rsp_data,
    input  logic                       rsp_ready,
    output logic                       busy
);

    localparam int IDW = $clog2(N_REQ);
    // Wait counter holds LAT-1 down to 0; at least one bit wide for LAT=1.
    localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [CW-1:0]      r_wait_cnt;
    logic [WIDTH-1:0]   r_add_a;
    logic [WIDTH-1:0]   r_add_b;
    logic               r_add_valid;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [WIDTH:0]     r_rsp_data;
    logic               r_busy;

    logic               w_found;
    logic [IDW-1:0]     w_grant_id;
    logic [IDW-1:0]     w_next_ptr;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic               w_accept;

    // Rotating-priority search: scan N_REQ positions starting at r_rr_ptr,
    // wrapping past N_REQ-1 back to 0, and take the first requester found.
    always_comb begin
        int idx;
        w_found    = 1'b0;
        w_grant_id = '0;
        idx        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!w_found && req_valid[idx]) begin
                w_found    = 1'b1;
                w_grant_id = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_op_a = req_a[int'(w_grant_id)*WIDTH +: WIDTH];
        w_op_b = req_b[int'(w_grant_id)*WIDTH +: WIDTH];
    end

    // Pointer moves to the slot after the winner, so the winner gets lowest
    // priority on the next arbitration round.
    assign w_next_ptr = (w_grant_id == IDW'(N_REQ - 1)) ? '0 : (w_grant_id + IDW'(1));

    // Gated by rst so the accept strobe drops immediately on reset, even
    // though it is decoded combinationally from req_valid.
    assign w_accept  = (r_state == IDLE) && w_found && !rst;
    assign req_ready = w_accept ? (N_REQ'(1) << w_grant_id) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_wait_cnt  <= '0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_valid <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        // Operands and id are snapshotted here; later changes
                        // on the request ports cannot reach the in-flight op.
                        r_add_a     <= w_op_a;
                        r_add_b     <= w_op_b;
                        r_rsp_id    <= w_grant_id;
                        r_rr_ptr    <= w_next_ptr;
                        r_add_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_add_valid <= 1'b0;
                    r_wait_cnt  <= CW'(LAT - 1);
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_rsp_data  <= add_c;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_add_valid <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_valid = r_add_valid;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - self-checking bench for adder_arbiter

module tb_adder_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int LAT   = 1;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [WIDTH-1:0]       add_a;
    logic [WIDTH-1:0]       add_b;
    logic                   add_valid;
    logic [WIDTH:0]         add_c;
    logic                   rsp_valid;
    logic [1:0]             rsp_id;
    logic [WIDTH:0]         rsp_data;
    logic                   rsp_ready;
    logic                   busy;

    adder_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_valid (add_valid),
        .add_c     (add_c),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External adder with one cycle of latency; outside its valid window it
    // drives a poison value so an early or late sample shows up as a bad sum.
    logic           tb_sum_v;
    logic [WIDTH:0] tb_sum;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_sum_v <= 1'b0;
            tb_sum   <= '0;
        end else begin
            tb_sum_v <= add_valid;
            tb_sum   <= {1'b0, add_a} + {1'b0, add_b};
        end
    end
    assign add_c = tb_sum_v ? tb_sum : 9'h0AA;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        int          exp_id;
        logic [8:0]  exp_data;
    } vec_t;

    typedef struct {
        int         id;
        logic [8:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every completed response handshake must match the oldest
    // expectation pushed when its request was driven.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_unexpected: got id %0d data %0h expected no response", rsp_id, rsp_data);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("sb_rsp_id", 32'(rsp_id), 32'(e.id));
                chk("sb_rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
    end

    // Called at posedge+1 of the intended accept cycle; returns at posedge+1
    // of the cycle after the response handshake (the next accept opportunity).
    task automatic do_op(input vec_t v);
        rsp_t e;
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        rsp_ready = 1'b1;
        #1;
        chk("accept_req_ready", 32'(req_ready), 32'(4'b0001 << v.exp_id));
        chk("accept_busy", 32'(busy), 32'd0);
        e.id   = v.exp_id;
        e.data = v.exp_data;
        sb.push_back(e);
        @(posedge clk); #1;
        chk("issue_add_valid", 32'(add_valid), 32'd1);
        chk("issue_add_a", 32'(add_a), 32'(v.a[v.exp_id*8 +: 8]));
        chk("issue_add_b", 32'(add_b), 32'(v.b[v.exp_id*8 +: 8]));
        chk("issue_busy", 32'(busy), 32'd1);
        req_valid = 4'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        #1;
        chk("issue_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("wait_add_valid", 32'(add_valid), 32'd0);
        chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("wait_add_a_hold", 32'(add_a), 32'(v.a[v.exp_id*8 +: 8]));
        @(posedge clk); #1;
        chk("resp_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("resp_rsp_id", 32'(rsp_id), 32'(v.exp_id));
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    vec_t tbl[12];
    vec_t v;

    initial begin
        tbl[0]  = '{4'b1111, 32'h40302010, 32'h04030201, 0, 9'h011};
        tbl[1]  = '{4'b1111, 32'h40302010, 32'h04030201, 1, 9'h022};
        tbl[2]  = '{4'b1111, 32'h40302010, 32'h04030201, 2, 9'h033};
        tbl[3]  = '{4'b1111, 32'h40302010, 32'h04030201, 3, 9'h044};
        tbl[4]  = '{4'b1111, 32'h40302010, 32'h04030201, 0, 9'h011};
        tbl[5]  = '{4'b0100, 32'hAA0FBBCC, 32'h11012233, 2, 9'h010};
        tbl[6]  = '{4'b0100, 32'hAAFFBBCC, 32'h11012233, 2, 9'h100};
        tbl[7]  = '{4'b0100, 32'hAAFFBBCC, 32'h11FF2233, 2, 9'h1FE};
        tbl[8]  = '{4'b1000, 32'hC8010101, 32'h64010101, 3, 9'h12C};
        tbl[9]  = '{4'b1001, 32'h01020380, 32'h09080780, 0, 9'h100};
        tbl[10] = '{4'b0110, 32'h10207F30, 32'h01020103, 1, 9'h080};
        tbl[11] = '{4'b0011, 32'h112233FE, 32'h44556603, 0, 9'h101};

        // Reset state, checked before any clock edge with requests pending.
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = 32'hFFFFFFFF;
        req_b     = 32'hFFFFFFFF;
        rsp_ready = 1'b1;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_add_valid", 32'(add_valid), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_add_b", 32'(add_b), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i]);
        end

        // Backpressure: round-robin pointer is at 1, so requester 1 wins.
        req_valid = 4'b0010;
        req_a     = 32'h00003C00;
        req_b     = 32'h00000C00;
        rsp_ready = 1'b0;
        #1;
        chk("bp_accept", 32'(req_ready), 32'b0010);
        v.exp_id   = 1;
        v.exp_data = 9'h048;
        sb.push_back('{v.exp_id, v.exp_data});
        @(posedge clk); #1;
        req_valid = 4'b1111;
        req_a     = 32'h5A5A5A5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_id", 32'(rsp_id), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'h048);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        chk("bp_done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_busy", 32'(busy), 32'd0);

        // Reset in WAIT: pointer is at 2, so requester 2 is taken first.
        req_valid = 4'b0100;
        req_a     = 32'h00050000;
        req_b     = 32'h00060000;
        #1;
        chk("rstop_accept", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstop_add_a", 32'(add_a), 32'd0);
        chk("rstop_add_valid", 32'(add_valid), 32'd0);
        chk("rstop_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstop_rsp_data", 32'(rsp_data), 32'd0);
        chk("rstop_busy", 32'(busy), 32'd0);
        chk("rstop_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("rstop_no_rsp", 32'(rsp_valid), 32'd0);
        end
        v = '{4'b1010, 32'h99002100, 32'h01001200, 1, 9'h033};
        do_op(v);

        @(posedge clk); #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
